sc2bin_shft_arb: RTL and testbench

SC2BIN_SHFT_ARB -- requirements
Module: sc2bin_shft_arb

---
 rtl/sc2bin_shft_arb.sv | 180 ++++++++++++++++++
 tb/tb_sc2bin_shft_arb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sc2bin_shft_arb.sv
// Round-robin arbiter that shares one external combinational shifter among N_REQ requesters.
// Define SC2BIN_SHFT_ARB_PRIO_EN to give requester 0 absolute priority over the round-robin group.
module sc2bin_shft_arb #(
    parameter int BITWIDTH_IN  = 10,
    parameter int BITWIDTH_OUT = 8,
    parameter int N_REQ        = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*BITWIDTH_IN-1:0]  req_data,
    input  logic [N_REQ*3-1:0]            req_amt,
    output logic [N_REQ-1:0]              req_ready,
    output logic [BITWIDTH_IN-1:0]        shft_in,
    output logic [2:0]                    shft_amt,
    output logic                          act_en,
    input  logic [BITWIDTH_OUT-1:0]       shft_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BITWIDTH_OUT-1:0]       out_data,
    output logic [$clog2(N_REQ)-1:0]      out_id,
    output logic [15:0]                   txn_cnt
);

    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [ID_W-1:0]         ptr_reg, ptr_next;
    logic [BITWIDTH_IN-1:0]  op_data_reg;
    logic [2:0]              op_amt_reg;
    logic [ID_W-1:0]         op_id_reg;
    logic [BITWIDTH_OUT-1:0] out_data_reg;
    logic [ID_W-1:0]         out_id_reg;
    logic [15:0]             txn_cnt_reg;

    logic                    grant_en;
    logic                    gnt_found;
    logic [ID_W-1:0]         gnt_idx;
    logic                    grant;
    logic                    accept;

    logic [BITWIDTH_IN-1:0]  data_arr [N_REQ];
    logic [2:0]              amt_arr  [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[gi*BITWIDTH_IN +: BITWIDTH_IN];
            assign amt_arr[gi]  = req_amt[gi*3 +: 3];
        end
    endgenerate

    // Descending scan so the requester closest after the pointer is the last (winning) assignment.
    always_comb begin
        logic [ID_W:0] cand;
        cand      = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = {1'b0, ptr_reg} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (req_valid[cand[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[ID_W-1:0];
            end
        end
`ifdef SC2BIN_SHFT_ARB_PRIO_EN
        if (req_valid[0]) begin
            gnt_found = 1'b1;
            gnt_idx   = '0;
        end
`endif
    end

    assign grant  = grant_en && gnt_found;
    assign accept = out_valid && out_ready;

    // Pointer tracks the last round-robin winner; priority grants to requester 0 leave it alone.
    always_comb begin
        ptr_next = ptr_reg;
`ifdef SC2BIN_SHFT_ARB_PRIO_EN
        if (grant && (gnt_idx != '0)) begin
            ptr_next = gnt_idx;
        end
`else
        if (grant) begin
            ptr_next = gnt_idx;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = RESULT;
            end
            RESULT: begin
                if (out_ready) begin
                    state_next = grant ? ISSUE : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        grant_en  = 1'b0;
        act_en    = 1'b0;
        out_valid = 1'b0;
        case (state_reg)
            IDLE:    grant_en  = 1'b1;
            ISSUE:   act_en    = 1'b1;
            RESULT: begin
                out_valid = 1'b1;
                grant_en  = out_ready;
            end
            default: grant_en = 1'b0;
        endcase
        req_ready = '0;
        if (grant) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg      <= ID_W'(N_REQ-1);
            op_data_reg  <= '0;
            op_amt_reg   <= 3'd7;
            op_id_reg    <= '0;
            out_data_reg <= '0;
            out_id_reg   <= '0;
            txn_cnt_reg  <= '0;
        end else begin
            ptr_reg <= ptr_next;
            if (grant) begin
                op_data_reg <= data_arr[gnt_idx];
                op_amt_reg  <= amt_arr[gnt_idx];
                op_id_reg   <= gnt_idx;
            end
            if (act_en) begin
                out_data_reg <= shft_out;
                out_id_reg   <= op_id_reg;
            end
            if (accept) begin
                txn_cnt_reg <= txn_cnt_reg + 16'd1;
            end
        end
    end

    assign shft_in  = op_data_reg;
    assign shft_amt = op_amt_reg;
    assign out_data = out_data_reg;
    assign out_id   = out_id_reg;
    assign txn_cnt  = txn_cnt_reg;

endmodule

// File: tb/tb_sc2bin_shft_arb.sv
// Randomized scoreboard bench for sc2bin_shft_arb with a transaction-level arbitration model.
module tb_sc2bin_shft_arb;

    localparam int N   = 4;
    localparam int BWI = 10;
    localparam int BWO = 8;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*BWI-1:0] req_data = '0;
    logic [N*3-1:0]  req_amt = '0;
    logic [N-1:0]    req_ready;
    logic [BWI-1:0]  shft_in;
    logic [2:0]      shft_amt;
    logic            act_en;
    logic [BWO-1:0]  shft_out;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [BWO-1:0]  out_data;
    logic [1:0]      out_id;
    logic [15:0]     txn_cnt;

    sc2bin_shft_arb #(.BITWIDTH_IN(BWI), .BITWIDTH_OUT(BWO), .N_REQ(N)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_amt(req_amt), .req_ready(req_ready), .shft_in(shft_in), .shft_amt(shft_amt),
        .act_en(act_en), .shft_out(shft_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id), .txn_cnt(txn_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [BWO-1:0] ref_shift(input logic [BWI-1:0] d, input logic [2:0] a);
        logic [BWI-1:0] t;
        case (a)
            3'd5:    t = d >> 1;
            3'd6:    t = d >> 2;
            3'd7:    t = d;
            default: t = d << a;
        endcase
        return t[BWO-1:0];
    endfunction

    // Shifter output is deliberately corrupted when not enabled, so a mistimed capture shows up.
    assign shft_out = act_en ? ref_shift(shft_in, shft_amt) : ~ref_shift(shft_in, shft_amt);

    typedef struct packed {
        logic [BWO-1:0] data;
        logic [1:0]     id;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] exp_cnt = '0;
    int          total = 0;
    int          bad = 0;
    int          m_ptr = N-1;
    int          m_stage = 0;   // 0: free, 1: operand at shifter, 2: result presented

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] v, input int ptr);
`ifdef SC2BIN_SHFT_ARB_PRIO_EN
        if (v[0]) return 0;
`endif
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (ptr + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            req_data[i*BWI +: BWI] = BWI'($urandom);
            req_amt[i*3 +: 3]      = 3'($urandom);
        end
    endtask

    // One clock of stimulus: entered and left at posedge+1.
    task automatic cycle(input logic [N-1:0] v, input logic rdy);
        logic [N-1:0] exp_rdy;
        int           g;
        bit           can;
        exp_t         e;
        req_valid = v;
        out_ready = rdy;
        #1;
        can = (m_stage == 0) || (m_stage == 2 && rdy);
        g = can ? model_pick(v, m_ptr) : -1;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_stage == 2));
        chk("act_en", 32'(act_en), 32'(m_stage == 1));
        if (g >= 0) begin
            e.data = ref_shift(req_data[g*BWI +: BWI], req_amt[g*3 +: 3]);
            e.id   = 2'(g);
            exp_q.push_back(e);
`ifdef SC2BIN_SHFT_ARB_PRIO_EN
            if (g != 0) m_ptr = g;
`else
            m_ptr = g;
`endif
        end
        @(posedge clk);
        #1;
        if (g >= 0) m_stage = 1;
        else if (m_stage == 1) m_stage = 2;
        else if (m_stage == 2 && rdy) m_stage = 0;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        exp_q.delete();
        exp_cnt = '0;
        m_stage = 0;
        m_ptr   = N-1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Monitor: checks every presented result against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            chk("txn_cnt", 32'(txn_cnt), 32'(exp_cnt));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_unexpected: got out_valid=1 expected no result at %0t", $time);
                end else begin
                    chk("out_data", 32'(out_data), 32'(exp_q[0].data));
                    chk("out_id", 32'(out_id), 32'(exp_q[0].id));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        exp_cnt = exp_cnt + 16'd1;
                    end
                end
            end
        end
    end

    initial begin
        do_reset();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_act_en", 32'(act_en), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_id", 32'(out_id), 32'h0);
        chk("rst_shft_in", 32'(shft_in), 32'h0);
        chk("rst_shft_amt", 32'(shft_amt), 32'h7);
        chk("rst_txn_cnt", 32'(txn_cnt), 32'h0);

        // Single request from requester 0: 0x005 << 2 = 0x14
        rand_data();
        req_data[0 +: BWI] = 10'h005;
        req_amt[0 +: 3]    = 3'd2;
        cycle(4'b0001, 1'b0);
        cycle(4'b0000, 1'b0);
        chk("single_out_valid", 32'(out_valid), 32'h1);
        chk("single_out_data", 32'(out_data), 32'h14);
        chk("single_out_id", 32'(out_id), 32'h0);
        cycle(4'b0000, 1'b1);
        chk("single_txn_cnt", 32'(txn_cnt), 32'h1);

        // Back-to-back full load: five grants from reset, then drain
        do_reset();
        for (int i = 0; i < 9; i++) begin
            rand_data();
            cycle(4'b1111, 1'b1);
        end
        repeat (3) cycle(4'b0000, 1'b1);
        chk("burst_txn_cnt", 32'(txn_cnt), 32'd5);

        // Consumer stall in RESULT for 10 cycles
        rand_data();
        cycle(4'b1111, 1'b1);
        cycle(4'b1111, 1'b0);
        repeat (10) cycle(4'b1111, 1'b0);
        repeat (3) cycle(4'b0000, 1'b1);

        // Reset asserted while an operand is at the shifter
        rand_data();
        cycle(4'b0010, 1'b1);
        chk("pre_rst_in_issue", 32'(act_en), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_txn_cnt", 32'(txn_cnt), 32'h0);
        chk("midrst_act_en", 32'(act_en), 32'h0);
        exp_q.delete();
        exp_cnt = '0;
        m_stage = 0;
        m_ptr   = N-1;
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) cycle(4'b0000, 1'b1);

        // Counter wrap: preload near the top, then complete two handshakes
        force dut.txn_cnt_reg = 16'hFFFE;
        #1;
        release dut.txn_cnt_reg;
        exp_cnt = 16'hFFFE;
        chk("preload_txn_cnt", 32'(txn_cnt), 32'hFFFE);
        for (int i = 0; i < 2; i++) begin
            rand_data();
            cycle(4'b0100, 1'b1);
            cycle(4'b0000, 1'b1);
            cycle(4'b0000, 1'b1);
        end
        chk("wrap_txn_cnt", 32'(txn_cnt), 32'h0);

        // Randomized traffic, including requests withdrawn before a grant
        for (int i = 0; i < 400; i++) begin
            rand_data();
            cycle(N'($urandom), ($urandom_range(0, 9) < 7));
        end
        repeat (4) cycle(4'b0000, 1'b1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
